pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage LC-3b pipeline.
- Drives the load enables of the PC and all four inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives the squash controls: flush into IF/ID, NOP control-word injection into ID/EX.
- Resolves instruction-memory stalls, data-memory stalls, taken-branch redirects and load-use hazards, and keeps saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 77 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage LC-3b pipeline
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [2:0]       id_sr1,
  input  logic             id_sr1_used,
  input  logic [2:0]       id_sr2,
  input  logic             id_sr2_used,
  input  logic [2:0]       ex_dest,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             ifid_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, ISTALL, DSTALL, BUBBLE} state_t;
  state_t           state_q, state_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             dstall, istall, freeze, lu, redirect, lu_stall;
  // Hazard terms and priority-ordered decode; reset forces a full squash with nothing loading.
  always_comb begin
    dstall      = dmem_req & ~dmem_resp;
    istall      = imem_read & ~imem_resp;
    freeze      = dstall | istall;
    lu          = ifid_valid_q & ex_mem_read &
                  ((id_sr1_used & (id_sr1 == ex_dest)) | (id_sr2_used & (id_sr2 == ex_dest)));
    redirect    = ~freeze & ex_br_taken;
    lu_stall    = ~freeze & ~ex_br_taken & lu;
    load_idex   = ~reset & ~freeze;
    load_exmem  = load_idex;
    load_memwb  = load_idex;
    load_pc     = load_idex & ~lu_stall;
    load_ifid   = load_pc;
    flush_ifid  = reset | redirect;
    bubble_idex = reset | redirect | lu_stall;
  end
  // Next state, IF/ID validity and saturating counters.
  always_comb begin
    state_d      = dstall ? DSTALL : istall ? ISTALL : lu_stall ? BUBBLE : RUN;
    ifid_valid_d = flush_ifid ? 1'b0 : load_ifid ? 1'b1 : ifid_valid_q;
    stall_d      = (~load_pc & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d      = (redirect & ~&flush_q) ? flush_q + CNT_W'(1) : flush_q;
  end
  // State registers; an asynchronous reset abandons any stall in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      ifid_valid_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end
  assign state        = state_q;
  assign ifid_valid   = ifid_valid_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus randomized check against a behavioural model
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  logic clk = 0, reset = 1;
  logic imem_read = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
  logic [2:0] id_sr1 = 0, id_sr2 = 0, ex_dest = 0;
  logic id_sr1_used = 0, id_sr2_used = 0, ex_mem_read = 0, ex_br_taken = 0;
  logic load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, bubble_idex, ifid_valid;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  int n_chk = 0, n_pass = 0;
  int m_state = 0, m_valid = 0, m_stall = 0, m_flush = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .id_sr1(id_sr1), .id_sr1_used(id_sr1_used),
    .id_sr2(id_sr2), .id_sr2_used(id_sr2_used), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .ex_br_taken(ex_br_taken), .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .ifid_valid(ifid_valid), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One cycle: apply inputs, check decode against the model, clock, check registered state.
  task automatic step(input logic rst, ir, irs, dr, drs, br, mr, input logic [2:0] ed, s1,
                      input logic u1, input logic [2:0] s2, input logic u2);
    int kind, exp_loads, n_state, n_valid;
    bit lu;
    reset = rst; imem_read = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
    ex_br_taken = br; ex_mem_read = mr; ex_dest = ed; id_sr1 = s1; id_sr1_used = u1;
    id_sr2 = s2; id_sr2_used = u2;
    #1;
    // kind: 0 data stall, 1 fetch stall, 2 redirect, 3 load-use, 4 normal, 5 reset
    lu = (m_valid == 1) && mr && ((u1 && s1 == ed) || (u2 && s2 == ed));
    kind = rst ? 5 : (dr && !drs) ? 0 : (ir && !irs) ? 1 : br ? 2 : lu ? 3 : 4;
    exp_loads = (kind == 4 || kind == 2) ? 31 : (kind == 3) ? 7 : 0;
    chk("loads", {load_pc, load_ifid, load_idex, load_exmem, load_memwb}, exp_loads);
    chk("flush", flush_ifid, int'(kind == 2 || kind == 5));
    chk("bubble", bubble_idex, int'(kind >= 2 && kind != 4));
    n_state = kind == 0 ? 2 : kind == 1 ? 1 : kind == 3 ? 3 : 0;
    n_valid = (kind == 2 || kind == 5) ? 0 : (exp_loads == 31) ? 1 : m_valid;
    if (rst) begin
      m_state = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_state = n_state; m_valid = n_valid;
      if (exp_loads != 31) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (kind == 2) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end
    @(posedge clk);
    #1;
    chk("state", state, m_state);
    chk("ifid_valid", ifid_valid, m_valid);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
  endtask

  initial begin
    @(posedge clk); #1;
    step(1, 0,0, 0,0, 0,0, 0,0,0, 0,0);
    step(1, 0,0, 0,0, 0,0, 0,0,0, 0,0);
    step(0, 0,0, 0,0, 0,0, 0,0,0, 0,0);
    for (int i = 0; i < 3; i++) step(0, 1,0, 0,0, 0,0, 0,0,0, 0,0);
    chk("t2_istall_count", stall_cycles, 3);
    step(0, 1,1, 0,0, 0,0, 0,0,0, 0,0);
    step(0, 0,0, 0,0, 0,1, 3,3,1, 0,0);
    chk("t3_bubble_state", state, 3);
    step(0, 0,0, 0,0, 0,0, 3,3,1, 0,0);
    for (int i = 0; i < 2; i++) step(0, 1,0, 0,0, 1,0, 0,0,0, 0,0);
    step(0, 1,1, 0,0, 1,0, 0,0,0, 0,0);
    chk("t4_flush_count", flush_count, 1);
    chk("t4_valid_cleared", ifid_valid, 0);
    step(0, 0,0, 0,0, 0,1, 5,0,0, 5,1);
    step(0, 0,0, 1,0, 1,1, 2,2,1, 0,0);
    chk("t5_dstall_state", state, 2);
    step(0, 0,0, 1,1, 1,1, 2,2,1, 0,0);
    chk("t5_redirect_count", flush_count, 2);
    for (int i = 0; i < 20; i++) step(0, 0,0, 1,0, 0,0, 0,0,0, 0,0);
    chk("t6_saturated", stall_cycles, CMAX);
    step(1, 1,0, 1,0, 0,0, 0,0,0, 0,0);
    step(0, 0,0, 0,0, 0,0, 0,0,0, 0,0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
